// File: rtl/uart_tx_drain_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_drain_ctrl_if
// Bundles the FIFO-side and transmitter-side signals of the drain sequencer.
//
// Signal names keep the drain controller's point of view (_i = into the
// controller, _o = out of it).
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_o     FIFO read strobe, one-cycle pulse
//   fifo_data_i   FIFO registered read data (valid the cycle after fifo_rd_o)
//   tx_data_o     word presented to the transmitter
//   tx_start_o    frame start request
//   tx_busy_i     transmitter busy while a frame is shifting
//
// Handshakes:
//   FIFO: fifo_rd_o is a one-cycle strobe, only issued when fifo_empty_i is
//   low. The popped word appears on fifo_data_i exactly one cycle later.
//   Transmitter: tx_start_o acts as "valid" and is held, together with a
//   stable tx_data_o, until tx_busy_i is sampled high ("accepted"). The
//   frame is finished when tx_busy_i falls again.
//
// Modports: master = drain controller, slave = FIFO + transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_drain_ctrl_if #(
  parameter int WORD = 8
);
  logic            fifo_empty_i;
  logic            fifo_rd_o;
  logic [WORD-1:0] fifo_data_i;
  logic [WORD-1:0] tx_data_o;
  logic            tx_start_o;
  logic            tx_busy_i;

  modport master (
    input  fifo_empty_i, fifo_data_i, tx_busy_i,
    output fifo_rd_o, tx_data_o, tx_start_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, tx_busy_i,
    input  fifo_rd_o, tx_data_o, tx_start_o
  );
endinterface

// File: rtl/uart_tx_drain_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_drain_ctrl
// Sequencer between the UART TX FIFO and the UART transmitter. Pops one word
// at a time (accounting for the FIFO's one-cycle registered read latency),
// hands it to the transmitter with a start request, waits for the frame to
// finish and then inserts GAP_CYCLES idle cycles before the next pop.
//
// Parameters:
//   WORD        data word width (matches the FIFO)
//   GAP_CYCLES  idle cycles inserted after each frame (0 = back-to-back)
//   CNT_W       width of the sent-frame counter
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   en_i         drain enable, only looked at in IDLE
//   cts_n_i      active-low clear-to-send (only with UART_TX_CTS_EN defined)
//   bus          FIFO/transmitter signals (uart_tx_drain_ctrl_if.master)
//   busy_o       high in every state except IDLE
//   frame_cnt_o  frames handed to the transmitter since reset (wraps)
//   dbg_state_o  current FSM state, for debug and checkers
//
// Optional feature macro: UART_TX_CTS_EN
//   Defined   -> cts_n_i port plus 2-flop synchronizer; no pop while the
//                synchronized CTS is deasserted.
//   Undefined -> no port, CTS treated as always asserted.
//
// All outputs are registered; output flops are loaded from the next-state
// value so that e.g. fifo_rd_o is high exactly during the POP state.
// ---------------------------------------------------------------------------
module uart_tx_drain_ctrl #(
  parameter int WORD       = 8,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
`ifdef UART_TX_CTS_EN
  input  logic                  cts_n_i,
`endif
  uart_tx_drain_ctrl_if.master  bus,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      frame_cnt_o,
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             cts_ok;

  // ---------------------------------------------------------------------
  // Clear-to-send qualification
  // ---------------------------------------------------------------------
`ifdef UART_TX_CTS_EN
  // Reset to "not clear" so nothing is popped until the remote end has
  // been seen asserting CTS through both synchronizer stages.
  logic [1:0] cts_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], cts_n_i};
    end
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en_i && !bus.fifo_empty_i && !bus.tx_busy_i && cts_ok) begin
          state_nxt = ST_POP;
        end
      end
      ST_POP:  state_nxt = ST_LOAD;
      // The FIFO data registered from the POP strobe is valid here.
      ST_LOAD: state_nxt = ST_START;
      ST_START: begin
        if (bus.tx_busy_i) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.tx_busy_i) begin
          state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        // Counter holds the remaining gap cycles including this one.
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      busy_o         <= 1'b0;
      bus.fifo_rd_o  <= 1'b0;
      bus.tx_start_o <= 1'b0;
      bus.tx_data_o  <= '0;
      frame_cnt_o    <= '0;
      gap_cnt        <= '0;
    end else begin
      state          <= state_nxt;
      busy_o         <= (state_nxt != ST_IDLE);
      bus.fifo_rd_o  <= (state_nxt == ST_POP);
      bus.tx_start_o <= (state_nxt == ST_START);

      if (state == ST_LOAD) begin
        bus.tx_data_o <= bus.fifo_data_i;
      end

      // Count the frame at the handoff edge (start seen as accepted).
      if (state == ST_START && bus.tx_busy_i) begin
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      end

      if (state == ST_WAIT && !bus.tx_busy_i) begin
        gap_cnt <= GAP_W'(GAP_CYCLES);
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  assign dbg_state_o = state;

endmodule

// File: doc/uart_tx_drain_ctrl.md
Name: uart_tx_drain_ctrl

Overview:
Sequencer between the UART TX FIFO and the UART transmitter. It pops one word at a time from the FIFO and hands it to the transmitter with a start pulse. It then waits for the frame to complete and enforces a programmable inter-frame gap before popping the next word. It accounts for the FIFO's one-cycle registered read latency and owns the FIFO read strobe exclusively.

Parameters:
WORD, 8, data word width; matches FIFO WORD.
GAP_CYCLES, 0, idle clk_i cycles inserted after each frame completes (0 = back-to-back).
CNT_W, 16, width of the sent-frame counter.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  drain enable; sampled in IDLE only
fifo_empty_i  in  1  FIFO empty flag
fifo_rd_o  out  1  FIFO read strobe, one-cycle pulse
fifo_data_i  in  WORD  FIFO registered output data
tx_data_o  out  WORD  word presented to the transmitter
tx_start_o  out  1  frame start request
tx_busy_i  in  1  transmitter busy (high while a frame is shifting)
busy_o  out  1  high in any state other than IDLE
frame_cnt_o  out  CNT_W  frames handed off since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state): state = IDLE; fifo_rd_o = 0, tx_start_o = 0, busy_o = 0, tx_data_o = 0, frame_cnt_o = 0, gap counter = 0. A word popped but not yet started is discarded.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE: if en_i & !fifo_empty_i & !tx_busy_i -> POP; otherwise stay.
  - POP: fifo_rd_o = 1 for exactly this cycle -> LOAD.
  - LOAD: capture fifo_data_i into tx_data_o at the end of this cycle. The FIFO presents the popped word here, one cycle after the strobe. -> START.
  - START: tx_start_o = 1, held until tx_busy_i is sampled high. On that edge: tx_start_o -> 0, frame_cnt_o += 1, -> WAIT.
  - WAIT: stay while tx_busy_i = 1. On tx_busy_i = 0: -> GAP with counter loaded to GAP_CYCLES, or -> IDLE directly if GAP_CYCLES = 0.
  - GAP: decrement the counter each cycle; at 0 -> IDLE.
- tx_data_o is stable from the exit of LOAD until the next LOAD.
- Minimum per-frame overhead outside transmitter time: POP + LOAD + START ≥ 3 cycles, plus GAP_CYCLES, plus 1 IDLE cycle.
- fifo_rd_o is never asserted while fifo_empty_i = 1. It is also never asserted in two consecutive cycles.
- en_i deasserted mid-frame: the current frame completes, including the gap; the block then halts in IDLE. en_i is not sampled outside IDLE.
- FIFO refilled during WAIT/GAP: no effect until IDLE is re-entered.
- tx_busy_i already high in IDLE (transmitter used by another agent): remain in IDLE.
- frame_cnt_o wrap: 2^CNT_W-1 -> 0, no flag.

Optional Feature:
UART_TX_CTS_EN:
- Defined: adds port cts_n_i (in, 1, active-low clear-to-send from the remote end). cts_n_i passes through a 2-flop synchronizer, and the IDLE -> POP condition additionally requires the synchronized value = 0. CTS changes never abort a frame in POP..GAP; words are never popped while CTS is deasserted.
- Undefined: port absent, CTS treated as permanently asserted, no synchronizer flops.

Test Plan:
- Reset, en_i=1, FIFO holds 0xA5, transmitter busy for 10 cycles after start -> fifo_rd_o pulses once; tx_data_o=0xA5 after LOAD; tx_start_o high until busy seen; frame_cnt_o=1; back in IDLE with busy_o=0.
- GAP_CYCLES=4, FIFO holds 0x11,0x22,0x33 -> three frames in order; exactly 4 GAP cycles plus 1 IDLE cycle between each tx_busy_i fall and the next fifo_rd_o; frame_cnt_o=3; no rd while empty.
- en_i dropped during WAIT of frame 1 with 2 words queued -> frame 1 completes; no further fifo_rd_o; frame_cnt_o=1; restore en_i -> word 2 sent.
- rst_i asserted in LOAD -> outputs return to reset values asynchronously; tx_start_o never pulses for that word; frame_cnt_o=0.
- CNT_W=2, send 5 frames -> frame_cnt_o sequence 1,2,3,0,1.
- UART_TX_CTS_EN defined, cts_n_i=1 with data queued -> no fifo_rd_o; drive cts_n_i=0 -> fifo_rd_o exactly 3 cycles later (2 sync + IDLE decision); cts_n_i=1 during WAIT -> frame completes, next pop held.
